sumador_serie: RTL and testbench
================================

// Module: sumador_serie
//
// PURPOSE
// Bit-serial N-bit adder built around one sumador_completo instance (the 1-bit full adder)
// plus a carry flip-flop. Loads two N-bit operands and a carry-in, then adds one bit per
// clock, LSB first, feeding the registered carry back into the full adder's Cin.
// Parallel result (S, Cout) is presented with a one-cycle done pulse.
// Small-area alternative to a ripple chain of N full adders.
//
// PARAMETERS
// N   8   operand/result width in bits; legal range N >= 2
//
// PORTS
// clk    in   1   single clock; all state updates on rising edge
// reset  in   1   asynchronous, active-high reset
// start  in   1   request; sampled only in IDLE
// A      in   N   operand A; captured on the accepting edge
// B      in   N   operand B; captured on the accepting edge
// Cin    in   1   carry-in; captured on the accepting edge
// S      out  N   registered sum; holds until the next completion
// Cout   out  1   registered carry-out; holds until the next completion
// busy   out  1   high from the accepting edge through the done cycle
// done   out  1   one-cycle pulse; S/Cout valid from this cycle onward
//
// BEHAVIOUR
// - Reset (asynchronous, any time, including mid-operation): state=IDLE.
//   S=0, Cout=0, busy=0, done=0, internal shift registers/carry/counter=0.
//   No partial result is ever exposed after reset.
// - FSM states: IDLE, SUMA, FIN.
//   - IDLE & start=1 at edge t0: ra<=A, rb<=B, c<=Cin, cnt<=0, busy<=1, ->SUMA.
//   - IDLE & start=0: hold all state.
// - SUMA, each edge: full adder computes s,co from (ra[0], rb[0], c).
//   - Updates: rs<={s, rs[N-1:1]}, ra<=ra>>1, rb<=rb>>1, c<=co, cnt<=cnt+1.
//   - On the edge with cnt==N-1 (edge t0+N): S<={s, rs[N-1:1]}, Cout<=co, done<=1, ->FIN.
// - FIN, next edge (t0+N+1): done<=0, busy<=0, ->IDLE.
// - Latency: start accepted at t0 -> done=1 during the cycle after edge t0+N.
//   Exactly N add cycles. Next start can be accepted at edge t0+N+2 at the earliest.
// - start while busy (SUMA or FIN) is ignored; no queuing.
// - A/B/Cin changes after the accepting edge have no effect on the running addition.
// - Arithmetic: {Cout,S} == A + B + Cin (N+1 bits), modulo nothing. Overflow is
//   reported only through Cout.
// - Counter width: $clog2(N). Counter and shifts must not wrap beyond N bits processed.
// - done is high for exactly one cycle per accepted start. busy and done are never
//   high in IDLE.
//
// TESTING
// 1 N=8, reset, A=8'h00 B=8'h00 Cin=0 start -> done after 8 add cycles, S=8'h00, Cout=0.
// 2 A=8'hFF B=8'h01 Cin=0 -> S=8'h00, Cout=1. A=8'h5A B=8'h33 Cin=1 -> S=8'h8E, Cout=0.
// 3 A=8'hFF B=8'hFF Cin=1 -> S=8'hFF, Cout=1.
//   Then pulse start and change A/B mid-operation -> same result, exactly one done pulse.
// 4 Assert reset at add cycle 4 -> S=0, Cout=0, busy=0, done=0 immediately (async).
//   New start afterwards completes correctly.
// 5 N=3, exhaustive over all A, B, Cin (128 cases), back-to-back starts at the earliest
//   legal edge -> {Cout,S}==A+B+Cin each time. busy/done timing checked per case.

Source files
------------

// File: rtl/sumador_serie.sv
// Bit-serial N-bit adder: one full adder plus a carry flip-flop, one bit per clock, LSB first.
// The parallel sum and carry-out are registered and flagged with a one-cycle done pulse.

module sumador_completo (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

module sumador_serie #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  output logic [N-1:0] S,
  output logic         Cout,
  output logic         busy,
  output logic         done
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUMA = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t        state_r;
  logic [N-1:0]  ra_r;
  logic [N-1:0]  rb_r;
  logic [N-1:0]  rs_r;
  logic          c_r;
  logic [CW-1:0] cnt_r;
  logic          fa_s;
  logic          fa_co_s;

  sumador_completo u_fa (
    .a    (ra_r[0]),
    .b    (rb_r[0]),
    .cin  (c_r),
    .s    (fa_s),
    .cout (fa_co_s)
  );

  // Control FSM, operand/result shifters, carry flop and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      ra_r    <= {N{1'b0}};
      rb_r    <= {N{1'b0}};
      rs_r    <= {N{1'b0}};
      c_r     <= 1'b0;
      cnt_r   <= {CW{1'b0}};
      S       <= {N{1'b0}};
      Cout    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            ra_r    <= A;
            rb_r    <= B;
            c_r     <= Cin;
            cnt_r   <= {CW{1'b0}};
            busy    <= 1'b1;
            state_r <= SUMA;
          end else begin
            busy    <= 1'b0;
            state_r <= IDLE;
          end
        end
        SUMA: begin
          rs_r <= {fa_s, rs_r[N-1:1]};
          ra_r <= {1'b0, ra_r[N-1:1]};
          rb_r <= {1'b0, rb_r[N-1:1]};
          c_r  <= fa_co_s;
          // The final bit goes straight into S; the counter parks at zero instead of wrapping.
          if (cnt_r == LAST_BIT) begin
            cnt_r   <= {CW{1'b0}};
            S       <= {fa_s, rs_r[N-1:1]};
            Cout    <= fa_co_s;
            done    <= 1'b1;
            state_r <= FIN;
          end else begin
            cnt_r   <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
            state_r <= SUMA;
          end
        end
        FIN: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          cnt_r   <= {CW{1'b0}};
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sumador_serie.sv
// Self-checking bench for sumador_serie: directed and random sums at N=8, and an
// exhaustive back-to-back sweep at N=3, against plain integer addition.

module tb_sumador_serie;

  logic       clk = 1'b0;
  logic       reset;
  logic       start8;
  logic [7:0] a8, b8, s8;
  logic       cin8, cout8, busy8, done8;
  logic       start3;
  logic [2:0] a3, b3, s3;
  logic       cin3, cout3, busy3, done3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sumador_serie #(.N(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .A(a8), .B(b8), .Cin(cin8),
    .S(s8), .Cout(cout8), .busy(busy8), .done(done8)
  );

  sumador_serie #(.N(3)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .A(a3), .B(b3), .Cin(cin3),
    .S(s3), .Cout(cout3), .busy(busy3), .done(done3)
  );

  // One full N=8 operation starting at the sampling phase (#1 after a rising edge).
  // With disturb set, operands are scrambled and start is re-pulsed while busy.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                      input bit disturb, input string name);
    logic [8:0] expected;
    int         done_cnt;
    expected = {1'b0, a} + {1'b0, b} + {8'd0, cin};
    a8 = a; b8 = b; cin8 = cin; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    checks++;
    if (busy8 !== 1'b1 || done8 !== 1'b0) begin
      errors++;
      $display("FAIL %s_accept: busy=%b done=%b, required busy=1 done=0", name, busy8, done8);
    end
    done_cnt = 0;
    for (int k = 1; k <= 8; k++) begin
      if (disturb) begin
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
        start8 = (k == 3 || k == 7) ? 1'b1 : 1'b0;
      end
      @(posedge clk); #1;
      if (done8 === 1'b1) done_cnt++;
      if (k < 8) begin
        checks++;
        if (busy8 !== 1'b1 || done8 !== 1'b0) begin
          errors++;
          $display("FAIL %s_cycle%0d: busy=%b done=%b, required busy=1 done=0", name, k, busy8, done8);
        end
      end
    end
    start8 = 1'b0;
    checks++;
    if ({cout8, s8} !== expected || done8 !== 1'b1 || busy8 !== 1'b1) begin
      errors++;
      $display("FAIL %s_result: {Cout,S}=%h done=%b busy=%b, required %h done=1 busy=1",
               name, {cout8, s8}, done8, busy8, expected);
    end
    @(posedge clk); #1;
    checks++;
    if (busy8 !== 1'b0 || done8 !== 1'b0) begin
      errors++;
      $display("FAIL %s_fin: busy=%b done=%b, required busy=0 done=0", name, busy8, done8);
    end
    if (disturb) begin
      repeat (4) begin
        @(posedge clk); #1;
        if (done8 === 1'b1) done_cnt++;
      end
      checks++;
      if (done_cnt != 1 || {cout8, s8} !== expected || busy8 !== 1'b0) begin
        errors++;
        $display("FAIL %s_hold: done pulses=%0d {Cout,S}=%h busy=%b, required 1 pulse %h busy=0",
                 name, done_cnt, {cout8, s8}, busy8, expected);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start8 = 1'b0; start3 = 1'b0;
    a8 = 8'd0; b8 = 8'd0; cin8 = 1'b0; a3 = 3'd0; b3 = 3'd0; cin3 = 1'b0;
    #22;
    checks++;
    if (s8 !== 8'd0 || cout8 !== 1'b0 || busy8 !== 1'b0 || done8 !== 1'b0 ||
        s3 !== 3'd0 || cout3 !== 1'b0 || busy3 !== 1'b0 || done3 !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: s8=%h cout8=%b busy8=%b done8=%b s3=%h, required all zero",
               s8, cout8, busy8, done8, s3);
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    run8(8'h00, 8'h00, 1'b0, 1'b0, "zero");
    run8(8'hFF, 8'h01, 1'b0, 1'b0, "carry_out");
    run8(8'h5A, 8'h33, 1'b1, 1'b0, "mixed");
    run8(8'hFF, 8'hFF, 1'b1, 1'b0, "max");
  endtask

  task automatic test_operand_change();
    run8(8'hFF, 8'hFF, 1'b1, 1'b1, "disturb_max");
    run8(8'h81, 8'h7E, 1'b1, 1'b1, "disturb_mix");
  endtask

  task automatic test_reset_mid();
    a8 = 8'hC3; b8 = 8'h96; cin8 = 1'b1; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (s8 !== 8'd0 || cout8 !== 1'b0 || busy8 !== 1'b0 || done8 !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: S=%h Cout=%b busy=%b done=%b, required all zero",
               s8, cout8, busy8, done8);
    end
    #2 reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || s8 !== 8'd0) begin
      errors++;
      $display("FAIL reset_after: S=%h busy=%b done=%b, required idle with S=0", s8, busy8, done8);
    end
    run8(8'h5A, 8'h33, 1'b1, 1'b0, "after_reset");
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      run8(8'($urandom), 8'($urandom), 1'($urandom), 1'b0, "random");
    end
  endtask

  // Exhaustive N=3 with start held high: each op is accepted at the earliest legal edge,
  // and the next op's operands are applied right after acceptance.
  task automatic test_back_to_back();
    logic [6:0] v;
    logic [3:0] expected;
    v = 7'd0;
    a3 = v[2:0]; b3 = v[5:3]; cin3 = v[6]; start3 = 1'b1;
    for (int i = 0; i < 128; i++) begin
      @(posedge clk); #1;
      v = 7'(i);
      expected = {1'b0, v[2:0]} + {1'b0, v[5:3]} + {3'd0, v[6]};
      checks++;
      if (busy3 !== 1'b1 || done3 !== 1'b0) begin
        errors++;
        $display("FAIL b2b_accept case %0d: busy=%b done=%b, required busy=1 done=0", i, busy3, done3);
      end
      v = 7'(i + 1);
      a3 = v[2:0]; b3 = v[5:3]; cin3 = v[6];
      for (int k = 1; k <= 3; k++) begin
        @(posedge clk); #1;
        if (k < 3) begin
          checks++;
          if (busy3 !== 1'b1 || done3 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_cycle case %0d k=%0d: busy=%b done=%b, required busy=1 done=0",
                     i, k, busy3, done3);
          end
        end
      end
      checks++;
      if ({cout3, s3} !== expected || done3 !== 1'b1 || busy3 !== 1'b1) begin
        errors++;
        $display("FAIL b2b_result case %0d: {Cout,S}=%h done=%b busy=%b, required %h done=1 busy=1",
                 i, {cout3, s3}, done3, busy3, expected);
      end
      @(posedge clk); #1;
      checks++;
      if (busy3 !== 1'b0 || done3 !== 1'b0) begin
        errors++;
        $display("FAIL b2b_fin case %0d: busy=%b done=%b, required busy=0 done=0", i, busy3, done3);
      end
    end
    start3 = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    checks++;
    if (busy3 !== 1'b0 || done3 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: busy=%b done=%b, required busy=0 done=0", busy3, done3);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_operand_change();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
